// File: rtl/wavegen_dds.sv
// wavegen_dds: direct-digital-synthesis sample generator feeding spi2dac.
// A phase accumulator advances on each sample tick; the top phase bits are
// mapped to sine/sawtooth/triangle/square, then the excursion about midscale
// (512) is attenuated by a power of two. Three-stage pipeline, tick -> output
// in two cycles, fully pipelined for back-to-back ticks.
//
// Output handshake: sample_valid is a valid-only strobe with no ready. It is
// high for exactly the one cycle in which data_out takes a new value; data_out
// then holds until the next strobe, so the consumer may take it at any later
// point (spi2dac samples it on its own load).
module wavegen_dds #(
    parameter int PHASE_W = 16
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [1:0]         wave_sel,
    input  logic [1:0]         atten,
    output logic [9:0]         data_out,
    output logic               sample_valid
);

    localparam logic [1:0] WAVE_SINE = 2'b00;
    localparam logic [1:0] WAVE_SAW  = 2'b01;
    localparam logic [1:0] WAVE_TRI  = 2'b10;

    // Quarter-wave sine magnitudes, round(511*sin(2*pi*(k+0.5)/256)).
    // The half-step offset makes the wave symmetric, so no entry is zero
    // and the quadrant mirroring needs no special cases.
    localparam logic [8:0] SINE_Q [64] = '{
        9'd6,   9'd19,  9'd31,  9'd44,  9'd56,  9'd69,  9'd81,  9'd94,
        9'd106, 9'd118, 9'd130, 9'd142, 9'd154, 9'd166, 9'd178, 9'd190,
        9'd201, 9'd213, 9'd224, 9'd235, 9'd246, 9'd257, 9'd268, 9'd279,
        9'd289, 9'd299, 9'd309, 9'd319, 9'd329, 9'd338, 9'd348, 9'd357,
        9'd366, 9'd374, 9'd383, 9'd391, 9'd399, 9'd407, 9'd414, 9'd421,
        9'd428, 9'd435, 9'd441, 9'd448, 9'd454, 9'd459, 9'd465, 9'd470,
        9'd474, 9'd479, 9'd483, 9'd487, 9'd491, 9'd494, 9'd497, 9'd500,
        9'd502, 9'd505, 9'd506, 9'd508, 9'd509, 9'd510, 9'd511, 9'd511
    };

    // Stage 0 state: accumulator plus the controls captured with the tick.
    logic [PHASE_W-1:0] r_phase;
    logic               r_s1_valid;
    logic [1:0]         r_s1_sel;
    logic [1:0]         r_s1_atten;

    // Stage 1 state: raw waveform sample and the attenuation that goes with it.
    logic [9:0]         r_raw;
    logic               r_s2_valid;
    logic [1:0]         r_s2_atten;

    // w_top holds phase bits P[15:5]; the lower phase bits never reach the
    // waveform mapping, they only carry fractional frequency resolution.
    logic [10:0]        w_top;
    logic [5:0]         w_q_idx;
    logic [8:0]         w_q_mag;
    logic [9:0]         w_sine;
    logic [9:0]         w_raw;
    logic signed [10:0] w_exc;
    logic signed [10:0] w_att;
    logic [9:0]         w_out;

    assign w_top   = r_phase[PHASE_W-1 -: 11];

    // Quadrants 1 and 3 walk the table backwards (63-i == ~i for 6 bits);
    // the lower half-cycle mirrors about 511.5 rather than 512.
    assign w_q_idx = w_top[9] ? ~w_top[8:3] : w_top[8:3];
    assign w_q_mag = SINE_Q[w_q_idx];
    assign w_sine  = w_top[10] ? (10'd511 - {1'b0, w_q_mag})
                               : (10'd512 + {1'b0, w_q_mag});

    // Waveform select on the phase captured at the last tick.
    always_comb begin
        w_raw = 10'd0;
        case (r_s1_sel)
            WAVE_SINE: w_raw = w_sine;
            WAVE_SAW:  w_raw = w_top[10:1];
            WAVE_TRI:  w_raw = w_top[10] ? ~w_top[9:0] : w_top[9:0];
            default:   w_raw = {10{~w_top[10]}};
        endcase
    end

    // Signed excursion about midscale, arithmetic-shifted toward midscale.
    // The shifted value stays within -512..511, so re-centering cannot wrap.
    assign w_exc = $signed({1'b0, r_raw}) - 11'sd512;
    assign w_att = w_exc >>> r_s2_atten;
    assign w_out = 10'(w_att + 11'sd512);

    // Stage 0: advance the phase and capture controls on each tick.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sel   <= 2'b00;
            r_s1_atten <= 2'b00;
        end else begin
            r_s1_valid <= tick;
            if (tick) begin
                r_phase    <= r_phase + freq_word;
                r_s1_sel   <= wave_sel;
                r_s1_atten <= atten;
            end
        end
    end

    // Stage 1: register the raw waveform sample.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_raw      <= 10'd0;
            r_s2_valid <= 1'b0;
            r_s2_atten <= 2'b00;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_raw      <= w_raw;
                r_s2_atten <= r_s1_atten;
            end
        end
    end

    // Stage 2: attenuate and present the sample; hold it between updates.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            data_out     <= 10'd512;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= r_s2_valid;
            if (r_s2_valid) begin
                data_out <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_wavegen_dds.sv
// tb_wavegen_dds: self-checking bench for wavegen_dds. The reference model
// computes each sample straight from the waveform definitions using real
// arithmetic ($sin, floor division), independent of the design's tables.
module tb_wavegen_dds;

    localparam int  PW = 16;
    localparam real PI = 3.14159265358979;

    logic          sysclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          tick   = 1'b0;
    logic [PW-1:0] freq_word = '0;
    logic [1:0]    wave_sel  = 2'b00;
    logic [1:0]    atten     = 2'b00;
    logic [9:0]    data_out;
    logic          sample_valid;

    int         total = 0;
    int         bad   = 0;
    int         m_phase = 0;
    logic [9:0] m_last  = 10'd512;
    logic [9:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #10 sysclk = ~sysclk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    wavegen_dds #(.PHASE_W(PW)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .tick         (tick),
        .freq_word    (freq_word),
        .wave_sel     (wave_sel),
        .atten        (atten),
        .data_out     (data_out),
        .sample_valid (sample_valid)
    );

    // ---------------- reference model ----------------
    function automatic logic [9:0] model_sample(input int ph, input logic [1:0] sel,
                                                input logic [1:0] att);
        int  p;
        int  a;
        int  raw;
        int  exc;
        real s;
        p   = ph >> (PW - 16);
        raw = 0;
        case (sel)
            2'd0: begin
                a   = p / 256;
                s   = 511.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 256.0);
                raw = ((a < 128) ? 512 : 511) + int'(s);
            end
            2'd1: raw = p / 64;
            2'd2: raw = (p < 32768) ? (p / 32) : (1023 - (p - 32768) / 32);
            default: raw = (p < 32768) ? 1023 : 0;
        endcase
        exc = raw - 512;
        exc = int'($floor(real'(exc) / real'(1 << att)));
        return 10'(exc + 512);
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        tick  = 1'b0;
        repeat (cycles) @(negedge sysclk);
        rst_n   = 1'b1;
        m_phase = 0;
        m_last  = 10'd512;
        exp_q.delete();
    endtask

    // One-cycle tick; returns at the negedge after the sampling edge.
    task automatic drive_tick(input logic [PW-1:0] fw, input logic [1:0] sel,
                              input logic [1:0] att, output logic [9:0] exp_v);
        freq_word = fw;
        wave_sel  = sel;
        atten     = att;
        tick      = 1'b1;
        @(negedge sysclk);
        tick    = 1'b0;
        m_phase = (m_phase + int'(fw)) % (1 << PW);
        exp_v   = model_sample(m_phase, sel, att);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] e;
        rst_n = 1'b0;
        tick  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            total++;
            if (data_out !== 10'd512 || sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: data=%0d valid=%0b, want data=512 valid=0", data_out, sample_valid);
            end
        end
        rst_n   = 1'b1;
        m_phase = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            total++;
            if (data_out !== 10'd512 || sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: data=%0d valid=%0b, want data=512 valid=0", data_out, sample_valid);
            end
        end
        // freq_word=0: two ticks, both give the first sine sample 512+6.
        for (int k = 0; k < 2; k++) begin
            drive_tick(16'h0000, 2'b00, 2'b00, e);
            @(negedge sysclk);
            total++;
            if (sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_latency: valid=%0b one cycle after tick, want 0", sample_valid);
            end
            @(negedge sysclk);
            total++;
            if (sample_valid !== 1'b1 || data_out !== 10'd518) begin
                bad++;
                $display("FAIL first_sine: data=%0d valid=%0b, want data=518 valid=1", data_out, sample_valid);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge sysclk);
            total++;
            if (sample_valid !== 1'b0 || data_out !== 10'd518) begin
                bad++;
                $display("FAIL idle_hold: data=%0d valid=%0b, want data=518 valid=0", data_out, sample_valid);
            end
        end
    endtask

    task automatic test_sawtooth();
        logic [9:0] e;
        logic [9:0] want;
        int         gap;
        apply_reset(2);
        for (int n = 1; n <= 1024; n++) begin
            drive_tick(16'h0040, 2'b01, 2'b00, e);
            want = 10'(n % 1024);
            @(negedge sysclk);
            @(negedge sysclk);
            total++;
            if (sample_valid !== 1'b1 || data_out !== want) begin
                bad++;
                $display("FAIL saw_ramp n=%0d: data=%0d valid=%0b, want data=%0d valid=1", n, data_out, sample_valid, want);
            end
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge sysclk);
                total++;
                if (sample_valid !== 1'b0 || data_out !== want) begin
                    bad++;
                    $display("FAIL saw_hold n=%0d: data=%0d valid=%0b, want data=%0d valid=0", n, data_out, sample_valid, want);
                end
            end
        end
    endtask

    task automatic test_sine();
        logic [9:0] e;
        logic [9:0] fixed_v;
        apply_reset(2);
        for (int n = 1; n <= 191; n++) begin
            drive_tick(16'h0100, 2'b00, 2'b00, e);
            @(negedge sysclk);
            @(negedge sysclk);
            total++;
            if (sample_valid !== 1'b1 || data_out !== e) begin
                bad++;
                $display("FAIL sine_model n=%0d: data=%0d valid=%0b, want data=%0d valid=1", n, data_out, sample_valid, e);
            end
            if (n == 63 || n == 64 || n == 128 || n == 191) begin
                fixed_v = (n <= 64) ? 10'd1023 : ((n == 128) ? 10'd505 : 10'd0);
                total++;
                if (data_out !== fixed_v) begin
                    bad++;
                    $display("FAIL sine_quadrant n=%0d: data=%0d, want %0d", n, data_out, fixed_v);
                end
            end
        end
    endtask

    task automatic test_square_atten();
        logic [9:0] e;
        logic [1:0] att_list [3];
        logic [9:0] lo_list  [3];
        logic [9:0] hi_list  [3];
        logic [9:0] want;
        att_list = '{2'd0, 2'd1, 2'd3};
        lo_list  = '{10'd0, 10'd256, 10'd448};
        hi_list  = '{10'd1023, 10'd767, 10'd575};
        for (int j = 0; j < 3; j++) begin
            apply_reset(2);
            for (int k = 1; k <= 4; k++) begin
                drive_tick(16'h8000, 2'b11, att_list[j], e);
                want = (k % 2 == 1) ? lo_list[j] : hi_list[j];
                @(negedge sysclk);
                @(negedge sysclk);
                total++;
                if (sample_valid !== 1'b1 || data_out !== want || data_out !== e) begin
                    bad++;
                    $display("FAIL square_atten att=%0d k=%0d: data=%0d valid=%0b, want data=%0d (model %0d)",
                             att_list[j], k, data_out, sample_valid, want, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset(2);
        freq_word = 16'h0040;
        wave_sel  = 2'b01;
        atten     = 2'b00;
        tick      = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge sysclk);
            if (c == 4) tick = 1'b0;
            total++;
            if (c >= 3 && c <= 6) begin
                if (sample_valid !== 1'b1 || data_out !== 10'(c - 2)) begin
                    bad++;
                    $display("FAIL b2b c=%0d: data=%0d valid=%0b, want data=%0d valid=1", c, data_out, sample_valid, c - 2);
                end
            end else begin
                if (sample_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle c=%0d: valid=%0b, want 0", c, sample_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        apply_reset(2);
        for (int k = 1; k <= 2; k++) begin
            drive_tick(16'h0040, 2'b01, 2'b00, e);
            @(negedge sysclk);
            @(negedge sysclk);
        end
        total++;
        if (data_out !== 10'd2) begin
            bad++;
            $display("FAIL pre_reset: data=%0d, want 2", data_out);
        end
        // Tick, then reset at the following edge with tick held high.
        tick = 1'b1;
        @(negedge sysclk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sysclk);
            total++;
            if (data_out !== 10'd512 || sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset: data=%0d valid=%0b, want data=512 valid=0", data_out, sample_valid);
            end
        end
        rst_n   = 1'b1;
        tick    = 1'b0;
        m_phase = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            total++;
            if (data_out !== 10'd512 || sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL flushed: data=%0d valid=%0b, want data=512 valid=0", data_out, sample_valid);
            end
        end
        drive_tick(16'h0040, 2'b01, 2'b00, e);
        @(negedge sysclk);
        @(negedge sysclk);
        total++;
        if (sample_valid !== 1'b1 || data_out !== 10'd1) begin
            bad++;
            $display("FAIL restart: data=%0d valid=%0b, want data=1 valid=1", data_out, sample_valid);
        end
    endtask

    task automatic test_random();
        logic       d1;
        logic       d2;
        logic       d3;
        logic       t;
        logic [9:0] want;
        apply_reset(2);
        d1 = 1'b0;
        d2 = 1'b0;
        d3 = 1'b0;
        for (int cyc = 0; cyc < 403; cyc++) begin
            t         = (cyc < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            freq_word = PW'($urandom);
            wave_sel  = 2'($urandom_range(0, 3));
            atten     = 2'($urandom_range(0, 3));
            tick      = t;
            if (t) begin
                m_phase = (m_phase + int'(freq_word)) % (1 << PW);
                exp_q.push_back(model_sample(m_phase, wave_sel, atten));
            end
            @(negedge sysclk);
            d3 = d2;
            d2 = d1;
            d1 = t;
            total++;
            if (d3) begin
                want   = (exp_q.size() > 0) ? exp_q.pop_front() : 10'd0;
                m_last = want;
                if (sample_valid !== 1'b1 || data_out !== want) begin
                    bad++;
                    $display("FAIL random cyc=%0d: data=%0d valid=%0b, want data=%0d valid=1", cyc, data_out, sample_valid, want);
                end
            end else begin
                if (sample_valid !== 1'b0 || data_out !== m_last) begin
                    bad++;
                    $display("FAIL random_hold cyc=%0d: data=%0d valid=%0b, want data=%0d valid=0", cyc, data_out, sample_valid, m_last);
                end
            end
        end
        tick = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_drain: %0d samples never appeared, want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge sysclk);
        test_reset();
        test_sawtooth();
        test_sine();
        test_square_atten();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
